store_rmw: RTL and testbench
============================

# store_rmw

Store-path unit that narrows a 32-bit register value to byte, halfword or word width and writes it into word-only data memory. Sub-word stores use a read-modify-write sequence. The unit sits between the execute stage's store request and the data memory port. It is the store-side counterpart of the load-side width extender.

## Interface
- ADDR_W, 32, byte-address width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  store request valid
- req_ready  out  1  unit idle, request accepted when valid&ready
- req_addr  in  ADDR_W  byte address
- req_data  in  32  register value; low bits used for sub-word
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done: misaligned/illegal, no memory access made
- mem_addr  out  ADDR_W  word address (low 2 bits zero)
- mem_rd  out  1  read request, held until mem_rvalid
- mem_rdata  in  32  read data
- mem_rvalid  in  1  read data valid
- mem_wr  out  1  write request, held until mem_wack
- mem_wdata  out  32  full word to write
- mem_wack  in  1  write accepted

## Operation
- States: IDLE, READ, MERGE, WRITE, DONE.
- IDLE: req_ready=1. Request fields are latched on accept.
- Errors go to DONE with err=1. These are: half with addr[0]=1, word with addr[1:0]≠0, or size 11.
- Word store: IDLE→WRITE with mem_wdata=req_data.
- Byte/half store: IDLE→READ.
- READ: mem_rd=1 and mem_addr=word address. On mem_rvalid, mem_rdata is latched and the state moves to MERGE.
- MERGE: the latched word is merged with the data lanes. Lanes are little-endian:
  - byte: req_data[7:0] replaces bits [8*addr[1:0]+7 : 8*addr[1:0]];
  - half: req_data[15:0] replaces bits [16*addr[1]+15 : 16*addr[1]].
  - Unselected lanes keep their old value. Next state is WRITE.
- WRITE: mem_wr=1 and mem_wdata is stable. On mem_wack the state moves to DONE.
- DONE: done=1 for exactly one cycle, req_ready=0, then IDLE.
- mem_rd and mem_wr are never asserted together.
- Reset values: state IDLE, req_ready=1 after release, done=0, err=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- Reset asserted mid-operation: return to IDLE immediately and drop mem_rd/mem_wr asynchronously. The in-flight store is abandoned and is never retried.
- Simultaneous req_valid with reset release: ignored until the first edge after rst_n is high.

## Timing
- Latencies below assume same-cycle mem_rvalid/mem_wack; accept at edge T:
  - word store: WRITE at T+1, done at T+2;
  - byte/half store: READ at T+1, MERGE at T+2, WRITE at T+3, done at T+4;
  - error: done+err at T+1.
- Every cycle of memory stall adds exactly one cycle.
- done and err are registered outputs.
- The next request can be accepted in the cycle after DONE.

## Configuration
- STORE_RMW_FWD_EN defined:
  - The unit keeps a one-entry copy of the last word it wrote, as a valid bit plus word address and data.
  - Valid is cleared on reset.
  - A sub-word store to the same word address skips READ and goes IDLE→MERGE using the copy. Byte/half latency becomes done at T+3.
  - A word store updates the copy.
  - Valid only because this unit is the sole writer of data memory.
- STORE_RMW_FWD_EN undefined:
  - There is no copy.
  - Every sub-word store performs READ.

## Structure
- Shared package store_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the state enum.
- Sub-module store_lane_merge is purely combinational. Inputs: old word, req_data, size, addr[1:0]. Output: merged word.
- The FSM, latches and forwarding entry live in store_rmw.

## Test plan
- Byte store, addr 0x1002, data 0xAABBCCDD, memory holds 0x11223344 → mem_wdata=0x11DD3344, done at T+4, err=0.
- Half store, addr 0x1002, data 0x0000BEEF, old word 0x11223344 → mem_wdata=0xBEEF3344, mem_addr=0x1000.
- Word store, addr 0x1004, data 0xCAFEF00D → no mem_rd, mem_wr at T+1 with 0xCAFEF00D, done at T+2.
- Half store to 0x1001, and separately size 11 → done=err=1 at T+1, mem_rd and mem_wr never asserted.
- Byte store with mem_rvalid delayed 3 cycles → mem_rd held 4 cycles. Then assert rst_n=0 during WRITE → mem_wr drops immediately, req_ready=1 after release, no done.
- With STORE_RMW_FWD_EN: byte store to 0x2000, then byte store to 0x2003 with data 0x77 → second store issues no mem_rd, writes the first result with bits [31:24]=0x77, done at T+3.

Source files
------------

// File: rtl/store_pkg.sv
// store_pkg: size encodings and FSM states shared by the store path
package store_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_t;
endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge: drop a byte or halfword into its little-endian lane of an old word
// ports: old (word read from memory), data (low 16 bits of the store value),
//        size (SZ_BYTE selects byte, anything else half), ofs (byte address [1:0]),
//        merged (old word with the selected lane replaced)
module store_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old,
  input  logic [15:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  ofs,
  output logic [31:0] merged
);
  logic [31:0] mask, lanes;
  assign mask   = (size == SZ_BYTE) ? 32'h0000_00ff << {ofs, 3'b000} : 32'h0000_ffff << {ofs[1], 4'b0000};
  assign lanes  = (size == SZ_BYTE) ? {4{data[7:0]}} : {2{data}};
  assign merged = (old & ~mask) | (lanes & mask);
endmodule

// File: rtl/store_rmw.sv
// store_rmw: narrow a store to byte/half/word and write it to word-only memory via read-modify-write
// ports: clk, rst_n (async active-low); req_valid/req_ready/req_addr/req_data/req_size store request;
//        done/err completion pulse (err = misaligned or illegal size, no memory access);
//        mem_addr/mem_rd/mem_rdata/mem_rvalid word read; mem_wr/mem_wdata/mem_wack word write
// STORE_RMW_FWD_EN: keep a copy of the last written word so sub-word stores to it skip the read
module store_rmw
  import store_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_wack
);
  state_t state;
  logic [1:0] size_q, ofs_q;
  logic [15:0] data_q;
  logic [31:0] old_q, merged, fwd_d;
  logic [ADDR_W-3:0] waddr;
  logic bad, hit;
  assign waddr = req_addr[ADDR_W-1:2];
  assign bad = (req_size == 2'b11) | ((req_size == SZ_HALF) & req_addr[0]) | ((req_size == SZ_WORD) & |req_addr[1:0]);
`ifdef STORE_RMW_FWD_EN
  logic fwd_v;
  logic [ADDR_W-3:0] fwd_a;
  assign hit = fwd_v && (fwd_a == waddr);
  // the copy stays coherent only because nothing else writes data memory
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fwd_v <= 1'b0;
      fwd_a <= '0;
      fwd_d <= '0;
    end else if (state == WRITE && mem_wack) begin
      fwd_v <= 1'b1;
      fwd_a <= mem_addr[ADDR_W-1:2];
      fwd_d <= mem_wdata;
    end
`else
  assign hit   = 1'b0;
  assign fwd_d = '0;
`endif
  store_lane_merge u_merge (.old(old_q), .data(data_q), .size(size_q), .ofs(ofs_q), .merged(merged));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      size_q    <= '0;
      ofs_q     <= '0;
      data_q    <= '0;
      old_q     <= '0;
    end else
      case (state)
        IDLE: if (req_valid) begin
          size_q    <= req_size;
          ofs_q     <= req_addr[1:0];
          data_q    <= req_data[15:0];
          req_ready <= 1'b0;
          if (bad) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            mem_addr <= {waddr, 2'b00};
            if (req_size == SZ_WORD) begin
              state     <= WRITE;
              mem_wr    <= 1'b1;
              mem_wdata <= req_data;
            end else if (hit) begin
              state <= MERGE;
              old_q <= fwd_d;
            end else begin
              state  <= READ;
              mem_rd <= 1'b1;
            end
          end
        end
        READ: if (mem_rvalid) begin
          old_q  <= mem_rdata;
          mem_rd <= 1'b0;
          state  <= MERGE;
        end
        MERGE: begin
          mem_wdata <= merged;
          mem_wr    <= 1'b1;
          state     <= WRITE;
        end
        WRITE: if (mem_wack) begin
          mem_wr <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done      <= 1'b0;
          err       <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_store_rmw.sv
// tb_store_rmw: directed checks of store_rmw against hand-computed memory writes and latencies
module tb_store_rmw;
  import store_pkg::*;
`ifdef STORE_RMW_FWD_EN
  localparam int HALF_DONE = 3;
  localparam int HALF_RD = 0;
`else
  localparam int HALF_DONE = 4;
  localparam int HALF_RD = 1;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, done, err, mem_rd, mem_rvalid = 1'b0, mem_wr, mem_wack = 1'b0;
  logic [31:0] req_addr = '0, req_data = '0, mem_addr, mem_rdata = '0, mem_wdata;
  logic [1:0] req_size = '0;
  int asserts = 0, failures = 0, both = 0;
  int dk, rdn, wrn, wfirst, dcount;
  logic [31:0] wd, wa;
  logic e;
  always #5 clk = ~clk;
  store_rmw dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_size(req_size), .done(done), .err(err), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_wack(mem_wack)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    asserts++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // issue one store, act as memory (read data after rdelay extra cycles, same-cycle write ack)
  // and record when done arrives, counted in cycles after the accept edge
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                          input logic [31:0] old, input int rdelay, input bit hold,
                          output int k_done, output int n_rd, output int n_wr, output int k_wr,
                          output logic [31:0] w_data, output logic [31:0] w_addr, output logic e_out);
    int g;
    g = 0;
    k_done = -1; n_rd = 0; n_wr = 0; k_wr = 0; w_data = '0; w_addr = '0; e_out = 1'b0;
    mem_rdata = old;
    @(negedge clk);
    while (!req_ready && g < 20) begin
      g++;
      @(negedge clk);
    end
    req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (mem_rd && mem_wr) both++;
      if (mem_rd) n_rd++;
      mem_rvalid = mem_rd && (n_rd > rdelay);
      if (mem_wr) begin
        n_wr++;
        if (k_wr == 0) k_wr = k;
        w_data = mem_wdata;
        w_addr = mem_addr;
        if (hold) break;
      end
      mem_wack = mem_wr;
      if (done) begin
        k_done = k;
        e_out = err;
        break;
      end
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    mem_wack = 1'b0;
  endtask
  initial begin
    #22;
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_rd", {31'b0, mem_rd}, 32'd0);
    check("rst_wr", {31'b0, mem_wr}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    do_store(32'h1002, 32'hAABBCCDD, SZ_BYTE, 32'h11223344, 0, 1'b0, dk, rdn, wrn, wfirst, wd, wa, e);
    check("byte_wdata", wd, 32'h11DD3344);
    check("byte_addr", wa, 32'h0000_1000);
    check("byte_done", dk, 32'd4);
    check("byte_err", {31'b0, e}, 32'd0);
    check("byte_rd", rdn, 32'd1);
    do_store(32'h1002, 32'h0000BEEF, SZ_HALF, 32'h11223344, 0, 1'b0, dk, rdn, wrn, wfirst, wd, wa, e);
    check("half_wdata", wd, 32'hBEEF3344);
    check("half_addr", wa, 32'h0000_1000);
    check("half_done", dk, HALF_DONE);
    check("half_rd", rdn, HALF_RD);
    do_store(32'h1004, 32'hCAFEF00D, SZ_WORD, 32'h0, 0, 1'b0, dk, rdn, wrn, wfirst, wd, wa, e);
    check("word_rd", rdn, 32'd0);
    check("word_wdata", wd, 32'hCAFEF00D);
    check("word_addr", wa, 32'h0000_1004);
    check("word_wr_k", wfirst, 32'd1);
    check("word_done", dk, 32'd2);
    check("word_err", {31'b0, e}, 32'd0);
    do_store(32'h1001, 32'h1234, SZ_HALF, 32'h0, 0, 1'b0, dk, rdn, wrn, wfirst, wd, wa, e);
    check("mis_half_done", dk, 32'd1);
    check("mis_half_err", {31'b0, e}, 32'd1);
    check("mis_half_mem", rdn + wrn, 32'd0);
    do_store(32'h1000, 32'h1234, 2'b11, 32'h0, 0, 1'b0, dk, rdn, wrn, wfirst, wd, wa, e);
    check("ill_done", dk, 32'd1);
    check("ill_err", {31'b0, e}, 32'd1);
    check("ill_mem", rdn + wrn, 32'd0);
    do_store(32'h1006, 32'h5678, SZ_WORD, 32'h0, 0, 1'b0, dk, rdn, wrn, wfirst, wd, wa, e);
    check("mis_word_err", {31'b0, e}, 32'd1);
    check("mis_word_mem", rdn + wrn, 32'd0);
    do_store(32'h1001, 32'h00000055, SZ_BYTE, 32'h11223344, 3, 1'b0, dk, rdn, wrn, wfirst, wd, wa, e);
    check("slow_rd_cycles", rdn, 32'd4);
    check("slow_wdata", wd, 32'h11225544);
    check("slow_done", dk, 32'd7);
    do_store(32'h3000, 32'hFFFFFF99, SZ_BYTE, 32'h11223344, 0, 1'b0, dk, rdn, wrn, wfirst, wd, wa, e);
    check("lane0_wdata", wd, 32'h11223399);
    do_store(32'h3000, 32'h00001234, SZ_HALF, 32'h11223344, 0, 1'b0, dk, rdn, wrn, wfirst, wd, wa, e);
    check("half0_wdata", wd, 32'h11221234);
    do_store(32'h1002, 32'h000000AB, SZ_BYTE, 32'h11223344, 0, 1'b1, dk, rdn, wrn, wfirst, wd, wa, e);
    check("hold_wr", wrn, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_wr", {31'b0, mem_wr}, 32'd0);
    check("abort_rd", {31'b0, mem_rd}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || mem_rd || mem_wr) dcount++;
    end
    check("abort_quiet", dcount, 32'd0);
`ifdef STORE_RMW_FWD_EN
    do_store(32'h2000, 32'h00000012, SZ_BYTE, 32'hA0B0C0D0, 0, 1'b0, dk, rdn, wrn, wfirst, wd, wa, e);
    check("fwd_first", wd, 32'hA0B0C012);
    check("fwd_first_done", dk, 32'd4);
    do_store(32'h2003, 32'h00000077, SZ_BYTE, 32'hDEADBEEF, 0, 1'b0, dk, rdn, wrn, wfirst, wd, wa, e);
    check("fwd_rd", rdn, 32'd0);
    check("fwd_wdata", wd, 32'h77B0C012);
    check("fwd_done", dk, 32'd3);
`endif
    check("rd_wr_overlap", both, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule
